// File: rtl/lock_access_ctrl_if.sv
// Button/keypad levels in, single-cycle datapath commands and lock status out.
// Pure wiring bundle: no latency and no backpressure of its own.
interface lock_access_ctrl_if;
    logic       OPEN_BTN;
    logic       CLOSE_BTN;
    logic       SET_BTN;
    logic       KEY_P;
    logic       EQ;
    logic       OPEN_CMD;
    logic       CLOSE_CMD;
    logic       SET_CMD;
    logic       KEY_EN;
    logic       UNLOCKED;
    logic       LOCKOUT;
    logic       ALARM;
    logic [3:0] FAIL_CNT;

    modport master (
        output OPEN_BTN, CLOSE_BTN, SET_BTN, KEY_P, EQ,
        input  OPEN_CMD, CLOSE_CMD, SET_CMD, KEY_EN, UNLOCKED, LOCKOUT, ALARM, FAIL_CNT
    );

    modport slave (
        input  OPEN_BTN, CLOSE_BTN, SET_BTN, KEY_P, EQ,
        output OPEN_CMD, CLOSE_CMD, SET_CMD, KEY_EN, UNLOCKED, LOCKOUT, ALARM, FAIL_CNT
    );
endinterface

// File: rtl/lock_access_ctrl.sv
// Lock command sequencer: button edges -> datapath pulses, failure lockout, idle auto-relock.
// One cycle from first sampled button level to registered output; no backpressure, excess edges are dropped.
module lock_access_ctrl #(
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int RELOCK_CYCLES  = 5000,
    parameter int CNT_W          = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    lock_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_UNLOCKED, S_LOCKOUT} state_t;

    localparam logic [CNT_W-1:0] RELOCK_LD  = CNT_W'(RELOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCKOUT_LD = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [4:0]       MAX_W      = 5'(MAX_FAIL);
    localparam logic [3:0]       MAX_C      = 4'(MAX_FAIL);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [3:0]       fail_q, fail_d;
    logic             alarm_q, alarm_d;
    logic             open_cmd_q, open_cmd_d;
    logic             close_cmd_q, close_cmd_d;
    logic             set_cmd_q, set_cmd_d;
    logic             open_h, close_h, set_h, key_h;
    logic             open_e, close_e, set_e, key_e;
    logic             open_sel, set_sel;
    logic [4:0]       fail_inc;

    assign open_e   = bus.OPEN_BTN  & ~open_h;
    assign close_e  = bus.CLOSE_BTN & ~close_h;
    assign set_e    = bus.SET_BTN   & ~set_h;
    assign key_e    = bus.KEY_P     & ~key_h;

    // CLOSE beats SET beats OPEN; losers are simply dropped for this cycle
    assign set_sel  = set_e & ~close_e;
    assign open_sel = open_e & ~close_e & ~set_e;
    assign fail_inc = {1'b0, fail_q} + 5'd1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            fail_q      <= '0;
            alarm_q     <= 1'b0;
            open_cmd_q  <= 1'b0;
            close_cmd_q <= 1'b0;
            set_cmd_q   <= 1'b0;
            open_h      <= 1'b0;
            close_h     <= 1'b0;
            set_h       <= 1'b0;
            key_h       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            fail_q      <= fail_d;
            alarm_q     <= alarm_d;
            open_cmd_q  <= open_cmd_d;
            close_cmd_q <= close_cmd_d;
            set_cmd_q   <= set_cmd_d;
            open_h      <= bus.OPEN_BTN;
            close_h     <= bus.CLOSE_BTN;
            set_h       <= bus.SET_BTN;
            key_h       <= bus.KEY_P;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        fail_d      = fail_q;
        alarm_d     = alarm_q;
        open_cmd_d  = 1'b0;
        close_cmd_d = 1'b0;
        set_cmd_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (close_e) begin
                    close_cmd_d = 1'b1;
                end else if (open_sel) begin
                    if (bus.EQ) begin
                        open_cmd_d = 1'b1;
                        fail_d     = '0;
                        timer_d    = RELOCK_LD;
                        state_d    = S_UNLOCKED;
                    end else if (fail_inc >= MAX_W) begin
                        close_cmd_d = 1'b1;
                        fail_d      = MAX_C;
                        alarm_d     = 1'b1;
                        timer_d     = LOCKOUT_LD;
                        state_d     = S_LOCKOUT;
                    end else begin
                        // wrong code: clear the entered digits and count the miss
                        close_cmd_d = 1'b1;
                        fail_d      = fail_inc[3:0];
                    end
                end
            end
            S_UNLOCKED: begin
                if (close_e) begin
                    close_cmd_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (set_sel || key_e) begin
                    // activity reload takes precedence over an expiring timer
                    set_cmd_d = set_sel;
                    timer_d   = RELOCK_LD;
                end else if (timer_q == '0) begin
                    close_cmd_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    timer_d = timer_q - ONE;
                end
            end
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    fail_d  = '0;
                    alarm_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.OPEN_CMD  = open_cmd_q;
    assign bus.CLOSE_CMD = close_cmd_q;
    assign bus.SET_CMD   = set_cmd_q;
    assign bus.KEY_EN    = (state_q != S_LOCKOUT);
    assign bus.UNLOCKED  = (state_q == S_UNLOCKED);
    assign bus.LOCKOUT   = (state_q == S_LOCKOUT);
    assign bus.ALARM     = alarm_q;
    assign bus.FAIL_CNT  = fail_q;
endmodule
